tw_ram_ntt_nwc: RTL and testbench

- Run-time loadable twiddle store replacing the fixed per-stage twiddle ROMs; one instance serves every NTT stage and both directions (forward NTT, inverse INTT) for negacyclic convolution.
- Holds two tables, selected by mode: forward and inverse. Each table has 2^LOGN-1 LOGQ-bit words.
- A streaming load FSM fills one table at a time. A pipelined read port returns the twiddle for (mode, stage, addr) after DELAY cycles.
- Sits beside the butterfly datapath. The host loads the tables once per modulus change.

---
 rtl/tw_ram_ntt_nwc_if.sv | 31 +++
 rtl/tw_ram_ntt_nwc.sv | 130 +++++++++++++
 tb/tb_tw_ram_ntt_nwc.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tw_ram_ntt_nwc_if.sv
// Load-stream and twiddle-read bundle for the shared NTT/INTT twiddle store.
// The master side is the host/datapath and the slave side is the store.
interface tw_ram_ntt_nwc_if #(
  parameter int LOGN = 4,
  parameter int LOGQ = 64,
  parameter int SW   = 3
);
  logic            ld_start;
  logic            ld_mode;
  logic            s_valid;
  logic [LOGQ-1:0] s_data;
  logic            s_ready;
  logic            ld_busy;
  logic [1:0]      tbl_ok;
  logic            rd_valid;
  logic            rd_mode;
  logic [SW-1:0]   rd_stage;
  logic [LOGN-1:0] rd_addr;
  logic [LOGQ-1:0] b;
  logic            b_valid;

  modport master (
    output ld_start, ld_mode, s_valid, s_data, rd_valid, rd_mode, rd_stage, rd_addr,
    input  s_ready, ld_busy, tbl_ok, b, b_valid
  );

  modport slave (
    input  ld_start, ld_mode, s_valid, s_data, rd_valid, rd_mode, rd_stage, rd_addr,
    output s_ready, ld_busy, tbl_ok, b, b_valid
  );
endinterface

// File: rtl/tw_ram_ntt_nwc.sv
// Run-time loadable forward/inverse twiddle store; reads return after DELAY cycles, one per cycle.
// The load stream is throttled only by s_ready (high while loading); the read port never stalls.
module tw_ram_ntt_nwc #(
  parameter int LOGN  = 4,
  parameter int LOGQ  = 64,
  parameter int SW    = 3,
  parameter int DELAY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  tw_ram_ntt_nwc_if.slave     bus
);
  localparam int DEPTH = (1 << LOGN) - 1;
  localparam int AW    = LOGN;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          state_q;
  logic            mode_q;
  logic [AW-1:0]   wptr_q;
  logic [1:0]      tbl_ok_q;
  logic            s_ready_q;
  logic            ld_busy_q;

  logic [LOGQ-1:0] mem_ntt  [DEPTH];
  logic [LOGQ-1:0] mem_intt [DEPTH];

  logic            start_acc;
  logic            wr_en;
  logic [AW-1:0]   rd_mask;
  logic [AW-1:0]   rd_idx;
  logic            rd_hit;
  logic [LOGQ-1:0] rd_word;
  logic [LOGQ-1:0] b_d;

  logic [LOGQ-1:0] b1_q;
  logic            v1_q;

  assign start_acc = (state_q == IDLE) && bus.ld_start;
  assign wr_en     = (state_q == LOAD) && bus.s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      wptr_q    <= '0;
      tbl_ok_q  <= 2'b00;
      s_ready_q <= 1'b0;
      ld_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ld_start) begin
            mode_q                 <= bus.ld_mode;
            wptr_q                 <= '0;
            tbl_ok_q[bus.ld_mode]  <= 1'b0;
            state_q                <= LOAD;
            s_ready_q              <= 1'b1;
            ld_busy_q              <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            wptr_q <= wptr_q + AW'(1);
            // The last word re-validates the table and closes the stream on the same edge.
            if (wptr_q == AW'(DEPTH - 1)) begin
              tbl_ok_q[mode_q] <= 1'b1;
              state_q          <= IDLE;
              s_ready_q        <= 1'b0;
              ld_busy_q        <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (mode_q) mem_intt[wptr_q] <= bus.s_data;
      else        mem_ntt[wptr_q]  <= bus.s_data;
    end
  end

  // Stage s occupies flat indices 2^s-1 .. 2^(s+1)-2; a reload starting this edge already hides its table.
  always_comb begin
    rd_mask = (AW'(1) << bus.rd_stage) - AW'(1);
    rd_idx  = rd_mask + (bus.rd_addr & rd_mask);
    rd_hit  = ({1'b0, bus.rd_stage} < (SW+1)'(LOGN)) && tbl_ok_q[bus.rd_mode] &&
              !(start_acc && (bus.ld_mode == bus.rd_mode));
    rd_word = bus.rd_mode ? mem_intt[rd_idx] : mem_ntt[rd_idx];
    b_d     = rd_hit ? rd_word : LOGQ'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= bus.rd_valid;
      if (bus.rd_valid) b1_q <= b_d;
    end
  end

  generate
    if (DELAY == 2) begin : g_delay2
      logic [LOGQ-1:0] b2_q;
      logic            v2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) b2_q <= b1_q;
        end
      end
      assign bus.b       = b2_q;
      assign bus.b_valid = v2_q;
    end else begin : g_delay1
      assign bus.b       = b1_q;
      assign bus.b_valid = v1_q;
    end
  endgenerate

  assign bus.s_ready = s_ready_q;
  assign bus.ld_busy = ld_busy_q;
  assign bus.tbl_ok  = tbl_ok_q;
endmodule

// File: tb/tb_tw_ram_ntt_nwc.sv
// Bench for tw_ram_ntt_nwc: fixed read vectors plus randomized traffic against an array-based table model.
module tb_tw_ram_ntt_nwc;
  localparam int LOGN  = 4;
  localparam int LOGQ  = 64;
  localparam int SW    = 3;
  localparam int DELAY = 2;
  localparam int DEPTH = (1 << LOGN) - 1;

  typedef logic [63:0] tbl_t [DEPTH];
  typedef struct { bit v; logic [63:0] d; } pe_t;
  typedef struct { bit mode; logic [2:0] stage; logic [3:0] addr; logic [63:0] exp; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tw_ram_ntt_nwc_if #(.LOGN(LOGN), .LOGQ(LOGQ), .SW(SW)) bus ();

  tw_ram_ntt_nwc #(.LOGN(LOGN), .LOGQ(LOGQ), .SW(SW), .DELAY(DELAY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] m_tbl [2][DEPTH];
  bit   [1:0]  m_ok;
  bit          m_ld;
  bit          m_mode;
  int          m_ptr;
  logic [63:0] m_b;
  bit          m_bv;
  pe_t         pq[$];

  vec_t vt[10];
  tbl_t ntt_w, intt_w, ntt2_w, ntt3_w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.ld_start = 1'b0; bus.ld_mode = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.rd_valid = 1'b0; bus.rd_mode = 1'b0; bus.rd_stage = '0; bus.rd_addr = '0;
  endtask

  task automatic rand_read();
    bus.rd_valid = 1'b1;
    bus.rd_mode  = 1'($urandom_range(0, 1));
    bus.rd_stage = SW'($urandom_range(0, 5));
    bus.rd_addr  = 4'($urandom_range(0, 15));
  endtask

  // One clock: predict from the current inputs, advance the model, then compare after the edge.
  task automatic step();
    pe_t e;
    int  s;
    int  ix;
    e.v = bus.rd_valid;
    s   = int'(bus.rd_stage);
    if (s >= LOGN || !m_ok[bus.rd_mode] || (!m_ld && bus.ld_start && bus.ld_mode == bus.rd_mode))
      e.d = 64'd1;
    else begin
      ix  = (1 << s) - 1 + (int'(bus.rd_addr) & ((1 << s) - 1));
      e.d = m_tbl[bus.rd_mode][ix];
    end
    pq.push_back(e);
    e = pq.pop_front();
    if (e.v) m_b = e.d;
    m_bv = e.v;
    if (m_ld) begin
      if (bus.s_valid) begin
        m_tbl[m_mode][m_ptr] = bus.s_data;
        m_ptr++;
        if (m_ptr == DEPTH) begin
          m_ok[m_mode] = 1'b1;
          m_ld = 1'b0;
        end
      end
    end else if (bus.ld_start) begin
      m_ld = 1'b1;
      m_mode = bus.ld_mode;
      m_ptr = 0;
      m_ok[m_mode] = 1'b0;
    end
    @(posedge clk); #1;
    chk("s_ready", 64'(bus.s_ready), 64'(m_ld));
    chk("ld_busy", 64'(bus.ld_busy), 64'(m_ld));
    chk("tbl_ok",  64'(bus.tbl_ok),  64'(m_ok));
    chk("b_valid", 64'(bus.b_valid), 64'(m_bv));
    chk("b",       bus.b,            m_b);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_tbl_ok",  64'(bus.tbl_ok),  64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_ld_busy", 64'(bus.ld_busy), 64'd0);
    chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
    chk("rst_b",       bus.b,            64'd0);
    m_ok = 2'b00; m_ld = 1'b0; m_ptr = 0; m_b = '0; m_bv = 1'b0;
    pq.delete();
    repeat (DELAY - 1) pq.push_back('{v: 1'b0, d: 64'd0});
    idle_inputs();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // stop_after < 0 runs the load to completion; gap throttles s_valid to every other cycle.
  task automatic load(input bit mode, input tbl_t w, input bit gap, input bit rnd_rd, input int stop_after);
    int k = 0;
    int cyc = 0;
    bit was_ld;
    bus.ld_start = 1'b1; bus.ld_mode = mode;
    bus.s_valid = 1'b1; bus.s_data = w[0];
    if (rnd_rd) rand_read();
    step();
    bus.ld_start = 1'b0;
    while (m_ld && k != stop_after && cyc < 200) begin
      bus.s_valid  = gap ? (cyc % 2 == 1) : 1'b1;
      bus.s_data   = w[k];
      bus.ld_start = ($urandom_range(0, 7) == 0);
      bus.ld_mode  = 1'($urandom_range(0, 1));
      if (rnd_rd) rand_read();
      was_ld = m_ld;
      step();
      if (was_ld && bus.s_valid) k++;
      cyc++;
    end
    if (cyc >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL load_timeout: got %0d words, expected %0d", k, DEPTH);
    end
    if (stop_after < 0) chk("load_words", 64'(k), 64'(DEPTH));
    bus.ld_start = 1'b0; bus.s_valid = 1'b0; bus.rd_valid = 1'b0;
  endtask

  task automatic run_vectors();
    for (int i = 0; i < 10; i++) begin
      bus.rd_valid = 1'b1; bus.rd_mode = vt[i].mode;
      bus.rd_stage = vt[i].stage; bus.rd_addr = vt[i].addr;
      step();
      bus.rd_valid = 1'b0;
      repeat (DELAY - 1) step();
      chk($sformatf("vec%0d_b", i), bus.b, vt[i].exp);
      chk($sformatf("vec%0d_vld", i), 64'(bus.b_valid), 64'd1);
    end
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      rand_read();
      step();
    end
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      ntt_w[i]  = {$urandom, $urandom};
      intt_w[i] = {$urandom, $urandom};
      ntt2_w[i] = {$urandom, $urandom};
      ntt3_w[i] = {$urandom, $urandom};
    end
    ntt_w[0]   = 64'd2672356941328551034;
    ntt_w[1]   = 64'd3392617565049336557;
    ntt_w[2]   = 64'd5976068779477487504;
    intt_w[14] = 64'd1576457532180094608;
    intt_w[5]  = 64'd8524270730790435434;

    vt[0] = '{mode: 1'b0, stage: 3'd1, addr: 4'd1,  exp: 64'd5976068779477487504};
    vt[1] = '{mode: 1'b0, stage: 3'd0, addr: 4'd0,  exp: 64'd2672356941328551034};
    vt[2] = '{mode: 1'b0, stage: 3'd1, addr: 4'd0,  exp: 64'd3392617565049336557};
    vt[3] = '{mode: 1'b0, stage: 3'd0, addr: 4'd5,  exp: 64'd2672356941328551034};
    vt[4] = '{mode: 1'b1, stage: 3'd3, addr: 4'd7,  exp: 64'd1576457532180094608};
    vt[5] = '{mode: 1'b1, stage: 3'd2, addr: 4'd2,  exp: 64'd8524270730790435434};
    vt[6] = '{mode: 1'b1, stage: 3'd2, addr: 4'd6,  exp: 64'd8524270730790435434};
    vt[7] = '{mode: 1'b0, stage: 3'd5, addr: 4'd1,  exp: 64'd1};
    vt[8] = '{mode: 1'b1, stage: 3'd4, addr: 4'd0,  exp: 64'd1};
    vt[9] = '{mode: 1'b1, stage: 3'd3, addr: 4'd15, exp: 64'd1576457532180094608};

    do_reset();

    // Read before any table is loaded returns the default 1.
    bus.rd_valid = 1'b1; bus.rd_mode = 1'b0; bus.rd_stage = 3'd1; bus.rd_addr = 4'd0;
    step();
    bus.rd_valid = 1'b0;
    repeat (DELAY - 1) step();
    chk("unloaded_b", bus.b, 64'd1);
    chk("unloaded_vld", 64'(bus.b_valid), 64'd1);

    load(1'b0, ntt_w, 1'b0, 1'b0, -1);
    load(1'b1, intt_w, 1'b1, 1'b0, -1);
    run_vectors();

    rand_reads(200);

    load(1'b0, ntt2_w, 1'b0, 1'b1, -1);
    rand_reads(40);

    load(1'b0, ntt3_w, 1'b1, 1'b1, 7);
    do_reset();
    rand_reads(20);
    load(1'b0, ntt3_w, 1'b0, 1'b0, -1);
    load(1'b1, intt_w, 1'b0, 1'b1, -1);
    run_vectors_intt_only();
    rand_reads(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic run_vectors_intt_only();
    for (int i = 4; i < 10; i++) begin
      bus.rd_valid = 1'b1; bus.rd_mode = vt[i].mode;
      bus.rd_stage = vt[i].stage; bus.rd_addr = vt[i].addr;
      step();
      bus.rd_valid = 1'b0;
      repeat (DELAY - 1) step();
      chk($sformatf("revec%0d_b", i), bus.b, vt[i].exp);
    end
  endtask
endmodule
